// File: rtl/mul_unit.sv
// Shift-add 32x32 MUL/MLA unit: low 32 bits of op_a*op_b (+acc) to the bank write port, optional N/Z to CPSR.
// Latency: 32/BITS_PER_CYCLE RUN cycles + 1 DONE cycle; start is ignored while RUN, no queueing.
module mul_unit #(
   parameter int BITS_PER_CYCLE = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [31:0] acc,
   input  logic        accumulate,
   input  logic [3:0]  rd_select,
   input  logic        set_flags,
   input  logic [3:0]  cpsr_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [3:0]  write_select,
   output logic        write_en,
   output logic [3:0]  write_cpsr_data,
   output logic        write_cpsr_en
);

   localparam int N = 32 / BITS_PER_CYCLE;
   localparam logic [5:0] LAST = 6'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [31:0] prod;
   logic [31:0] prod_next;
   logic [5:0]  count;
   logic [3:0]  rd_q;
   logic        sf_q;
   logic [1:0]  cv_q;
   logic        load;

   // N and Z are regenerated from the product; only C and V pass through.
   logic unused_nz;
   assign unused_nz = ^cpsr_in[3:2];

   assign load = start && (state == IDLE || state == DONE);

   always_comb begin
      prod_next = prod;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (mplier[i]) prod_next = prod_next + (mcand << i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         mcand           <= '0;
         mplier          <= '0;
         prod            <= '0;
         count           <= '0;
         rd_q            <= '0;
         sf_q            <= 1'b0;
         cv_q            <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         result          <= '0;
         write_select    <= '0;
         write_en        <= 1'b0;
         write_cpsr_data <= '0;
         write_cpsr_en   <= 1'b0;
      end else begin
         done          <= 1'b0;
         write_en      <= 1'b0;
         write_cpsr_en <= 1'b0;
         if (load) begin
            mcand  <= op_a;
            mplier <= op_b;
            prod   <= accumulate ? acc : 32'd0;
            count  <= '0;
            rd_q   <= rd_select;
            sf_q   <= set_flags;
            cv_q   <= cpsr_in[1:0];
            busy   <= 1'b1;
            state  <= RUN;
         end else begin
            case (state)
               IDLE: ;
               RUN: begin
                  prod   <= prod_next;
                  mcand  <= mcand << BITS_PER_CYCLE;
                  mplier <= mplier >> BITS_PER_CYCLE;
                  count  <= count + 6'd1;
                  // Outputs are registered on the final RUN edge so they are valid for the whole DONE cycle.
                  if (count == LAST) begin
                     state           <= DONE;
                     done            <= 1'b1;
                     write_en        <= 1'b1;
                     write_cpsr_en   <= sf_q;
                     result          <= prod_next;
                     write_select    <= rd_q;
                     write_cpsr_data <= {prod_next[31], prod_next == 32'd0, cv_q};
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit; instance 1 (BITS_PER_CYCLE=2) is the main target, 0 and 2 cover widths 1 and 4.
module tb_mul_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] op_a, op_b, acc;
   logic        accumulate;
   logic [3:0]  rd_select;
   logic        set_flags;
   logic [3:0]  cpsr_in;

   logic        busy_s [3];
   logic        done_s [3];
   logic [31:0] result_s [3];
   logic [3:0]  wsel_s [3];
   logic        wen_s [3];
   logic [3:0]  cpsr_s [3];
   logic        cen_s [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mul_unit #(.BITS_PER_CYCLE(1 << g)) u_dut (
         .clk(clk), .reset(reset), .start(start),
         .op_a(op_a), .op_b(op_b), .acc(acc), .accumulate(accumulate),
         .rd_select(rd_select), .set_flags(set_flags), .cpsr_in(cpsr_in),
         .busy(busy_s[g]), .done(done_s[g]), .result(result_s[g]),
         .write_select(wsel_s[g]), .write_en(wen_s[g]),
         .write_cpsr_data(cpsr_s[g]), .write_cpsr_en(cen_s[g])
      );
   end

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  wsel;
      logic [3:0]  cpsr;
      logic        cen;
   } exp_t;

   exp_t sb[$];
   int vectors = 0;
   int miscompares = 0;

   // Drives one request; the following posedge is the start edge (cycle 1 of the latency count).
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic accum, input logic [3:0] rd, input logic sf,
                        input logic [3:0] cp, input bit push);
      exp_t e;
      op_a = a; op_b = b; acc = c; accumulate = accum;
      rd_select = rd; set_flags = sf; cpsr_in = cp; start = 1'b1;
      e.res  = a * b + (accum ? c : 32'd0);
      e.wsel = rd;
      e.cpsr = {e.res[31], e.res == 32'd0, cp[1:0]};
      e.cen  = sf;
      if (push) sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int cyc0, input int budget, output int cyc, output bit seen);
      cyc  = cyc0;
      seen = 1'b0;
      while (cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
         if (done_s[1]) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b1;
      op_a = 32'h1; op_b = 32'h1; acc = 32'h0; accumulate = 1'b0;
      rd_select = 4'hF; set_flags = 1'b1; cpsr_in = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({busy_s[1], done_s[1], result_s[1], wsel_s[1], wen_s[1], cpsr_s[1], cen_s[1]} !== 43'd0)
         begin miscompares++; $display("FAIL reset_outputs busy=%b done=%b result=%h wsel=%h wen=%b cpsr=%h cen=%b, required all zero",
            busy_s[1], done_s[1], result_s[1], wsel_s[1], wen_s[1], cpsr_s[1], cen_s[1]); end
      reset = 1'b0; start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({busy_s[1], done_s[1]} !== 2'b00)
         begin miscompares++; $display("FAIL reset_idle busy=%b done=%b, required 0 0", busy_s[1], done_s[1]); end
   endtask

   task automatic test_mul;
      int cyc; bit seen; exp_t e;
      issue(32'd3, 32'd5, 32'd0, 1'b0, 4'd4, 1'b1, 4'b0011, 1'b1);
      vectors++;
      if (busy_s[1] !== 1'b1)
         begin miscompares++; $display("FAIL mul_busy got %b, required 1", busy_s[1]); end
      wait_done(1, 60, cyc, seen);
      vectors++;
      if (!seen || cyc != 17)
         begin miscompares++; $display("FAIL mul_latency seen=%b cycles=%0d, required 17", seen, cyc); end
      e = sb.pop_front();
      vectors++;
      if ({result_s[1], wsel_s[1], cpsr_s[1], cen_s[1], wen_s[1]} !== {e.res, e.wsel, e.cpsr, e.cen, 1'b1})
         begin miscompares++; $display("FAIL mul_result got res=%h wsel=%h cpsr=%b cen=%b wen=%b, required res=%h wsel=%h cpsr=%b cen=%b wen=1",
            result_s[1], wsel_s[1], cpsr_s[1], cen_s[1], wen_s[1], e.res, e.wsel, e.cpsr, e.cen); end
      @(posedge clk); #1;
      vectors++;
      if ({done_s[1], wen_s[1], cen_s[1], busy_s[1]} !== 4'b0000 || result_s[1] !== 32'd15 || wsel_s[1] !== 4'd4)
         begin miscompares++; $display("FAIL mul_hold done=%b wen=%b cen=%b busy=%b res=%h wsel=%h, required 0 0 0 0 0000000f 4",
            done_s[1], wen_s[1], cen_s[1], busy_s[1], result_s[1], wsel_s[1]); end
   endtask

   task automatic test_mla_flags;
      int cyc; bit seen; exp_t e;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0: issue(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 1'b1, 4'd7, 1'b0, 4'b0000, 1'b1);
            1: issue(32'h80000000, 32'h1, 32'h55, 1'b0, 4'd1, 1'b1, 4'b0010, 1'b1);
            default: issue(32'h00010000, 32'h00010000, 32'd0, 1'b0, 4'd2, 1'b1, 4'b0000, 1'b1);
         endcase
         wait_done(1, 60, cyc, seen);
         vectors++;
         if (!seen || cyc != 17)
            begin miscompares++; $display("FAIL flags_latency case=%0d seen=%b cycles=%0d, required 17", k, seen, cyc); end
         e = sb.pop_front();
         vectors++;
         if ({result_s[1], wsel_s[1], cpsr_s[1], cen_s[1]} !== {e.res, e.wsel, e.cpsr, e.cen})
            begin miscompares++; $display("FAIL flags_result case=%0d got res=%h wsel=%h cpsr=%b cen=%b, required res=%h wsel=%h cpsr=%b cen=%b",
               k, result_s[1], wsel_s[1], cpsr_s[1], cen_s[1], e.res, e.wsel, e.cpsr, e.cen); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_start_in_run;
      int cyc; bit seen; exp_t e; int extra;
      issue(32'd11, 32'd13, 32'd0, 1'b0, 4'd3, 1'b0, 4'b0000, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      op_a = 32'd99; op_b = 32'd99; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(7, 60, cyc, seen);
      vectors++;
      if (!seen || cyc != 17)
         begin miscompares++; $display("FAIL run_ignore_latency seen=%b cycles=%0d, required 17", seen, cyc); end
      e = sb.pop_front();
      vectors++;
      if (result_s[1] !== e.res)
         begin miscompares++; $display("FAIL run_ignore_result got %h, required %h", result_s[1], e.res); end
      extra = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (done_s[1]) extra++;
      end
      vectors++;
      if (extra != 0)
         begin miscompares++; $display("FAIL run_ignore_extra_done got %0d pulses, required 0", extra); end
   endtask

   task automatic test_back_to_back;
      int cyc; bit seen; exp_t e;
      issue(32'd5, 32'd5, 32'd0, 1'b0, 4'd6, 1'b0, 4'b0000, 1'b1);
      wait_done(1, 60, cyc, seen);
      e = sb.pop_front();
      vectors++;
      if (!seen || result_s[1] !== e.res)
         begin miscompares++; $display("FAIL b2b_first seen=%b res=%h, required %h", seen, result_s[1], e.res); end
      issue(32'd7, 32'd6, 32'd0, 1'b0, 4'd9, 1'b1, 4'b0001, 1'b1);
      vectors++;
      if (busy_s[1] !== 1'b1 || done_s[1] !== 1'b0)
         begin miscompares++; $display("FAIL b2b_restart busy=%b done=%b, required 1 0", busy_s[1], done_s[1]); end
      wait_done(1, 60, cyc, seen);
      vectors++;
      if (!seen || cyc != 17)
         begin miscompares++; $display("FAIL b2b_latency seen=%b cycles=%0d, required 17", seen, cyc); end
      e = sb.pop_front();
      vectors++;
      if ({result_s[1], wsel_s[1], cpsr_s[1], cen_s[1]} !== {e.res, e.wsel, e.cpsr, e.cen} || result_s[1] !== 32'd42)
         begin miscompares++; $display("FAIL b2b_result got res=%h wsel=%h cpsr=%b cen=%b, required res=%h wsel=%h cpsr=%b cen=%b",
            result_s[1], wsel_s[1], cpsr_s[1], cen_s[1], e.res, e.wsel, e.cpsr, e.cen); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_op;
      int cyc; bit seen; exp_t e; int pulses;
      issue(32'd100, 32'd3, 32'd0, 1'b0, 4'd5, 1'b1, 4'b0011, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      vectors++;
      if ({busy_s[1], done_s[1], result_s[1], wsel_s[1], wen_s[1], cpsr_s[1], cen_s[1]} !== 43'd0)
         begin miscompares++; $display("FAIL midreset_outputs busy=%b done=%b res=%h wsel=%h wen=%b cpsr=%h cen=%b, required all zero",
            busy_s[1], done_s[1], result_s[1], wsel_s[1], wen_s[1], cpsr_s[1], cen_s[1]); end
      pulses = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done_s[1] || wen_s[1] || cen_s[1] || result_s[1] !== 32'd0) pulses++;
      end
      vectors++;
      if (pulses != 0)
         begin miscompares++; $display("FAIL midreset_no_write got %0d active cycles, required 0", pulses); end
      issue(32'd2, 32'd9, 32'd0, 1'b0, 4'd8, 1'b0, 4'b0000, 1'b1);
      wait_done(1, 60, cyc, seen);
      e = sb.pop_front();
      vectors++;
      if (!seen || cyc != 17 || result_s[1] !== e.res)
         begin miscompares++; $display("FAIL midreset_recover seen=%b cycles=%0d res=%h, required 17 cycles res=%h", seen, cyc, result_s[1], e.res); end
   endtask

   task automatic test_param_sweep;
      int lat [3];
      logic [31:0] res [3];
      int cyc;
      repeat (40) @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin lat[g] = 0; res[g] = '0; end
      issue(32'h12345678, 32'h9ABCDEF0, 32'd0, 1'b0, 4'd1, 1'b0, 4'b0000, 1'b0);
      cyc = 1;
      while (cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
         for (int g = 0; g < 3; g++) begin
            if (done_s[g] && lat[g] == 0) begin lat[g] = cyc; res[g] = result_s[g]; end
         end
      end
      for (int g = 0; g < 3; g++) begin
         vectors++;
         if (lat[g] != (32 >> g) + 1 || res[g] !== 32'h242D2080)
            begin miscompares++; $display("FAIL sweep_bpc%0d latency=%0d res=%h, required latency=%0d res=242d2080",
               1 << g, lat[g], res[g], (32 >> g) + 1); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_mul();
      test_mla_flags();
      test_start_in_run();
      test_back_to_back();
      test_reset_mid_op();
      test_param_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mul_unit.md
# mul_unit

Multi-cycle 32x32 multiplier for ARM MUL/MLA. It sits directly downstream of the register bank. It takes the multiplicand from read bus A, the multiplier from read bus B and an optional accumulator operand. It produces the low 32 bits of the product on the bank's write port, and optionally N/Z flags on the CPSR write port. A shift-add state machine retires BITS_PER_CYCLE multiplier bits per clock.

## Interface
- BITS_PER_CYCLE, 2, multiplier bits retired per RUN cycle; legal values 1, 2, 4; RUN length N = 32/BITS_PER_CYCLE
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE or DONE
- op_a  in  32  multiplicand (Rm), from bank read bus A
- op_b  in  32  multiplier (Rs), from bank read bus B
- acc  in  32  accumulator (Rn), used when accumulate=1
- accumulate  in  1  1 = MLA, 0 = MUL
- rd_select  in  4  destination register index
- set_flags  in  1  S bit
- cpsr_in  in  4  current {N,Z,C,V}, from bank CPSR read
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse when result is valid
- result  out  32  low 32 bits of op_a*op_b (+acc)
- write_select  out  4  latched rd_select
- write_en  out  1  equals done
- write_cpsr_data  out  4  {N,Z,C,V} for the CPSR write
- write_cpsr_en  out  1  done & latched set_flags

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch the following, then go to RUN with count=0:
  - mcand=op_a, mplier=op_b
  - prod = acc if accumulate=1, else 0
  - rd_select, set_flags, cpsr_in[1:0] (C,V)
- RUN, per cycle:
  - prod += mcand * mplier[BITS_PER_CYCLE-1:0], modulo 2^32
  - mcand <<= BITS_PER_CYCLE; mplier >>= BITS_PER_CYCLE; count++
  - After the Nth RUN cycle, go to DONE.
- DONE, one cycle:
  - done=1, write_en=1, result=prod, write_select=latched rd.
  - write_cpsr_data = {prod[31], prod==0, latched C, latched V}.
  - write_cpsr_en = latched set_flags.
  - Next state is RUN if start=1 (back-to-back, new operands latched as in IDLE), else IDLE.
- start in RUN: ignored. No queueing, no error.
- All arithmetic is unsigned modulo 2^32. Signed and unsigned low-32 products are identical. No early termination.
- result, write_select and write_cpsr_data hold their last DONE values until the next DONE.
- write_en and write_cpsr_en are low outside DONE.
- Reset values: state=IDLE; busy, done, write_en, write_cpsr_en = 0; result = 0; write_select = 0; write_cpsr_data = 0; internal registers cleared.
- Reset mid-RUN or in DONE: next cycle is IDLE with reset values. No write pulse is produced for the aborted operation.

## Timing
- start sampled high at posedge t (state IDLE): busy=1 from t. RUN occupies t..t+N-1. done=1 for exactly the cycle [t+N, t+N+1).
- Latency is N+1 cycles from start to done; N=16 at the default.
- Back-to-back: start held high continuously gives one done every N+1 cycles.
- All outputs are registered. No combinational path from any input to any output.
- Operand inputs must be stable only at the start edge. They are don't-care in RUN.
- Write-back timing: the bank captures write_data/write_select on its posedge with write_en. The mul_unit outputs are registered and stable throughout the DONE cycle.

## Test plan
- Reset: assert reset for 2 cycles with start=1 → all outputs 0 and busy=0. Deassert, keep start=0 → state stays IDLE, busy=0, done=0.
- MUL: op_a=3, op_b=5, accumulate=0, rd=4, set_flags=1, cpsr_in=4'b0011 → done exactly 17 cycles after the start edge (N=16), result=15, write_select=4, write_cpsr_data=4'b0011, write_cpsr_en=1.
- MLA wrap: op_a=op_b=0xFFFFFFFF, acc=2, accumulate=1, set_flags=0 → result=3, write_cpsr_en=0.
- Flags:
  - op_a=0x80000000, op_b=1, cpsr_in=4'b0010 → result=0x80000000, write_cpsr_data=4'b1010.
  - op_a=op_b=0x00010000 → result=0, Z=1, N=0.
- Busy/back-to-back:
  - Pulse start again in mid-RUN → ignored, single done.
  - Hold start=1 with new operands (7*6) during DONE → second done 17 cycles later with result=42.
- Reset mid-op: assert reset 5 cycles into RUN → no done/write_en pulse at any later point, outputs 0. A subsequent 2*9 completes with result=18.
- Parameter sweep: repeat 0x12345678*0x9ABCDEF0 at BITS_PER_CYCLE=1, 2, 4 → result 0x242D2080 at latencies 33, 17 and 9 cycles respectively.
